// File: rtl/reject_compactor_pkg.sv
// Shared types and defaults for the rejection-sample compactor.
package reject_pkg;
  localparam int Q_KYBER       = 3329;
  localparam int N_COEFFS_DEF  = 256;
  localparam int CAND_BITS_DEF = 12;

  typedef logic [CAND_BITS_DEF-1:0] coeff_t;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
endpackage

// File: rtl/reject_compactor_if.sv
// Sampler-input and coefficient-output streams of the compactor.
interface reject_compactor_if #(
  parameter int LANES     = 4,
  parameter int CAND_BITS = 12,
  parameter int IDX_W     = 8
);
  logic [LANES-1:0]           in_acc;
  logic [LANES*CAND_BITS-1:0] in_tdata;
  logic                       in_tvalid;
  logic                       req_more;
  logic [CAND_BITS-1:0]       coeff_tdata;
  logic                       coeff_tvalid;
  logic                       coeff_tready;
  logic                       coeff_tlast;
  logic [IDX_W-1:0]           coeff_idx;

  // The compactor is the master of the coefficient stream.
  modport master (
    input  in_acc, in_tdata, in_tvalid, coeff_tready,
    output req_more, coeff_tdata, coeff_tvalid, coeff_tlast, coeff_idx
  );

  modport slave (
    output in_acc, in_tdata, in_tvalid, coeff_tready,
    input  req_more, coeff_tdata, coeff_tvalid, coeff_tlast, coeff_idx
  );
endinterface

// File: rtl/reject_compactor_lane_compact.sv
// Prefix popcount of the accept mask: per-lane write offset and total count.
module lane_compact #(
  parameter int LANES = 4,
  parameter int OFF_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]            acc,
  output logic [LANES-1:0][OFF_W-1:0] offset,
  output logic [OFF_W-1:0]            total
);
  logic [OFF_W-1:0] run_sum;

  always_comb begin
    run_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      offset[i] = run_sum;
      run_sum   = run_sum + OFF_W'(acc[i]);
    end
    total = run_sum;
  end
endmodule

// File: rtl/reject_compactor.sv
// Packs accepted sampler lanes into a circular buffer and streams N_COEFFS coefficients.
// Optional REJECT_STATS_EN adds the rej_count port (rejected-lane counter).
module reject_compactor
  import reject_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int CAND_BITS  = CAND_BITS_DEF,
  parameter int N_COEFFS   = N_COEFFS_DEF,
  parameter int BUF_DEPTH  = 16,
  parameter int REQ_THRESH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic overflow,
`ifdef REJECT_STATS_EN
  output logic [15:0] rej_count,
`endif
  reject_compactor_if.master bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = $clog2(N_COEFFS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = $clog2(LANES + 1);

  state_t                     state;
  logic [LVL_W-1:0]           level;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           wr_total;
  logic [IDX_W-1:0]           idx_q;
  logic                       overflow_q;
  logic                       busy_q;
  logic                       done_q;
  logic [CAND_BITS-1:0]       mem [BUF_DEPTH];

  logic [LANES-1:0][OFF_W-1:0] lane_off;
  logic [OFF_W-1:0]            lane_total;
  logic                        accepting;
  logic                        coeff_valid;
  logic                        pop;
  logic                        drop;
  logic [CNT_W-1:0]            free_slots;
  logic [CNT_W-1:0]            room_left;
  logic [CNT_W-1:0]            want;
  logic [CNT_W-1:0]            push_cnt;
  logic [CNT_W-1:0]            wr_total_next;
  logic [LVL_W-1:0]            level_next;
  logic [LANES-1:0]            lane_we;
  logic [LANES-1:0][PTR_W-1:0] lane_slot;

  lane_compact #(.LANES(LANES), .OFF_W(OFF_W)) u_lane_compact (
    .acc    (bus.in_acc),
    .offset (lane_off),
    .total  (lane_total)
  );

  // Free space uses the current level only; a same-cycle pop gives no credit.
  always_comb begin
    accepting     = (state == FILL) && bus.in_tvalid;
    coeff_valid   = (level != '0) && ((state == FILL) || (state == DRAIN));
    pop           = coeff_valid && bus.coeff_tready;
    free_slots    = CNT_W'(BUF_DEPTH) - CNT_W'(level);
    room_left     = CNT_W'(N_COEFFS) - wr_total;
    want          = (CNT_W'(lane_total) < room_left) ? CNT_W'(lane_total) : room_left;
    push_cnt      = '0;
    drop          = 1'b0;
    if (accepting) begin
      push_cnt = (want < free_slots) ? want : free_slots;
      drop     = (want > free_slots);
    end
    wr_total_next = wr_total + push_cnt;
    level_next    = level + LVL_W'(push_cnt) - LVL_W'(pop);
    for (int i = 0; i < LANES; i++) begin
      lane_we[i]   = bus.in_acc[i] && (CNT_W'(lane_off[i]) < push_cnt);
      lane_slot[i] = wr_ptr + PTR_W'(lane_off[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (lane_we[i]) mem[lane_slot[i]] <= bus.in_tdata[i*CAND_BITS +: CAND_BITS];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      level      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wr_total   <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FILL;
            busy_q     <= 1'b1;
            level      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_total   <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
          end
        end
        FILL, DRAIN: begin
          level    <= level_next;
          wr_ptr   <= wr_ptr + PTR_W'(push_cnt);
          rd_ptr   <= rd_ptr + PTR_W'(pop);
          wr_total <= wr_total_next;
          idx_q    <= idx_q + IDX_W'(pop);
          if (drop) overflow_q <= 1'b1;
          if ((state == FILL) && (wr_total_next == CNT_W'(N_COEFFS))) begin
            state <= DRAIN;
          end else if ((state == DRAIN) && pop && bus.coeff_tlast) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REJECT_STATS_EN
  logic [15:0] rej_q;
  logic [16:0] rej_sum;

  assign rej_sum = {1'b0, rej_q} + 17'(LANES) - 17'(lane_total);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rej_q <= '0;
    end else if ((state == IDLE) && start) begin
      rej_q <= '0;
    end else if (accepting) begin
      rej_q <= rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
    end
  end

  assign rej_count = rej_q;
`endif

  assign bus.coeff_tvalid = coeff_valid;
  assign bus.coeff_tdata  = coeff_valid ? mem[rd_ptr] : '0;
  assign bus.coeff_idx    = idx_q;
  assign bus.coeff_tlast  = (idx_q == IDX_W'(N_COEFFS - 1));
  assign bus.req_more     = (state == FILL) && (level < LVL_W'(REQ_THRESH)) &&
                            (wr_total < CNT_W'(N_COEFFS));
  assign busy             = busy_q;
  assign done             = done_q;
  assign overflow         = overflow_q;
endmodule

// File: tb/tb_reject_compactor.sv
// Self-checking bench for reject_compactor: vector table, corner sequences, randomized run vs queue model.
module tb_reject_compactor;
  import reject_pkg::*;

  localparam int LANES  = 4;
  localparam int CB     = 12;
  localparam int N      = 256;
  localparam int DEPTH  = 16;
  localparam int THRESH = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic overflow;
`ifdef REJECT_STATS_EN
  logic [15:0] rej_count;
`endif

  always #5 clk = ~clk;

  reject_compactor_if #(.LANES(LANES), .CAND_BITS(CB), .IDX_W(8)) bus ();

  reject_compactor #(
    .LANES(LANES), .CAND_BITS(CB), .N_COEFFS(N), .BUF_DEPTH(DEPTH), .REQ_THRESH(THRESH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
`ifdef REJECT_STATS_EN
    .rej_count(rej_count),
`endif
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a plain queue of pending coefficients plus counters.
  int     m_phase;
  coeff_t m_q[$];
  int     m_wr;
  int     m_idx;
  int     m_rej;
  bit     m_ovf;

  coeff_t got[$];
  int     last_pos;

  typedef struct {
    logic [3:0]       acc;
    int               exp_cnt;
    logic [3:0][11:0] exp_vals;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    m_phase = 0;
    m_q.delete();
    m_wr  = 0;
    m_idx = 0;
    m_rej = 0;
    m_ovf = 1'b0;
  endfunction

  function automatic bit mValid();
    return ((m_phase == 1) || (m_phase == 2)) && (m_q.size() > 0);
  endfunction

  function automatic bit mReqMore();
    return (m_phase == 1) && (m_q.size() < THRESH) && (m_wr < N);
  endfunction

  function automatic void modelStep(input bit st, input logic [3:0] acc, input logic [47:0] data,
                                    input bit tv, input bit tr);
    coeff_t fresh[$];
    bit     do_pop;
    bit     last;
    int     k;
    int     free_n;
    int     cap;
    last = 1'b0;
    case (m_phase)
      0: if (st) begin
        modelReset();
        m_phase = 1;
      end
      3: m_phase = 0;
      default: begin
        do_pop = mValid() && tr;
        if ((m_phase == 1) && tv) begin
          free_n = DEPTH - m_q.size();
          cap    = N - m_wr;
          k      = 0;
          for (int i = 0; i < LANES; i++) begin
            if (acc[i]) begin
              if (k < cap) begin
                if (k < free_n) fresh.push_back(data[i*CB +: CB]);
                else m_ovf = 1'b1;
              end
              k++;
            end else begin
              m_rej = (m_rej < 65535) ? m_rej + 1 : 65535;
            end
          end
        end
        if (do_pop) begin
          last = (m_idx == N - 1);
          void'(m_q.pop_front());
          m_idx++;
        end
        foreach (fresh[j]) m_q.push_back(fresh[j]);
        m_wr += fresh.size();
        if ((m_phase == 1) && (m_wr == N)) m_phase = 2;
        else if ((m_phase == 2) && last) m_phase = 3;
      end
    endcase
  endfunction

  // One clock: compare outputs against the model, drive inputs, advance the model.
  task automatic applyStimulus(input bit st, input logic [3:0] acc, input logic [47:0] data,
                               input bit tv, input bit tr);
    @(negedge clk);
    checkOutput("busy", busy, (m_phase == 1) || (m_phase == 2));
    checkOutput("done", done, m_phase == 3);
    checkOutput("overflow", overflow, m_ovf);
    checkOutput("tvalid", bus.coeff_tvalid, mValid());
    checkOutput("req_more", bus.req_more, mReqMore());
    checkOutput("idx", bus.coeff_idx, m_idx % N);
    if (mValid()) begin
      checkOutput("tdata", bus.coeff_tdata, m_q[0]);
      checkOutput("tlast", bus.coeff_tlast, m_idx == N - 1);
    end
`ifdef REJECT_STATS_EN
    checkOutput("rej_count", rej_count, m_rej);
`endif
    if (bus.coeff_tvalid && tr) begin
      got.push_back(bus.coeff_tdata);
      if (bus.coeff_tlast) last_pos = got.size() - 1;
    end
    start            = st;
    bus.in_acc       = acc;
    bus.in_tdata     = data;
    bus.in_tvalid    = tv;
    bus.coeff_tready = tr;
    modelStep(st, acc, data, tv, tr);
    @(posedge clk);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst              = 1'b1;
    start            = 1'b0;
    bus.in_acc       = '0;
    bus.in_tdata     = '0;
    bus.in_tvalid    = 1'b0;
    bus.coeff_tready = 1'b0;
    modelReset();
    #2;
    rst = 1'b0;
  endtask

  // mode 0: full mask paced by req_more; 1: same with a 2-lane word at word 63; >=2: random.
  task automatic runToDone(input int mode, input int bound);
    logic [3:0]  a;
    logic [47:0] d;
    bit          tv;
    bit          tr;
    bit          counts;
    bit          reached;
    int          w;
    reached = 1'b0;
    w       = 0;
    for (int c = 0; c < bound && !reached; c++) begin
      if (mode == 0) begin
        a  = 4'hF;
        tv = mReqMore();
        tr = 1'b1;
      end else if (mode == 1) begin
        a  = (w == 63) ? 4'b0011 : 4'hF;
        tv = mReqMore();
        tr = 1'b1;
      end else begin
        a  = 4'($urandom);
        tv = ($urandom_range(0, 3) != 0);
        tr = ($urandom_range(0, mode) != 0);
      end
      for (int i = 0; i < LANES; i++)
        d[i*CB +: CB] = (mode < 2) ? 12'(w * 4 + i) : 12'($urandom);
      counts = tv && (m_phase == 1);
      applyStimulus(1'b0, a, d, tv, tr);
      if (counts) w++;
      if (m_phase == 3) reached = 1'b1;
    end
    checkOutput("reach_done", reached, 1);
    if (reached) begin
      #1;
      checkOutput("done_pulse", done, 1);
      applyStimulus(1'b0, 4'h0, '0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [47:0] dw;
    int          bad;
    dw = {12'd4, 12'd3, 12'd2, 12'd1};
    vecs[0] = '{4'b1010, 2, {12'd0, 12'd0, 12'd4, 12'd2}};
    vecs[1] = '{4'b1111, 4, {12'd4, 12'd3, 12'd2, 12'd1}};
    vecs[2] = '{4'b0001, 1, {12'd0, 12'd0, 12'd0, 12'd1}};
    vecs[3] = '{4'b0000, 0, {12'd0, 12'd0, 12'd0, 12'd0}};
    vecs[4] = '{4'b0110, 2, {12'd0, 12'd0, 12'd3, 12'd2}};
    vecs[5] = '{4'b1000, 1, {12'd0, 12'd0, 12'd0, 12'd4}};
    vecs[6] = '{4'b1101, 3, {12'd0, 12'd4, 12'd3, 12'd1}};

    rst              = 1'b1;
    start            = 1'b0;
    bus.in_acc       = '0;
    bus.in_tdata     = '0;
    bus.in_tvalid    = 1'b0;
    bus.coeff_tready = 1'b0;
    modelReset();
    last_pos = -1;
    #1;
    checkOutput("init_busy", busy, 0);
    checkOutput("init_done", done, 0);
    checkOutput("init_tvalid", bus.coeff_tvalid, 0);
    checkOutput("init_req_more", bus.req_more, 0);
    checkOutput("init_overflow", overflow, 0);
    #20;
    doReset();

    // Vector table: one word into a fresh polynomial, then drain and compare the output order.
    for (int v = 0; v < 7; v++) begin
      doReset();
      applyStimulus(1'b1, 4'h0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, vecs[v].acc, dw, 1'b1, 1'b0);
      got.delete();
      repeat (6) applyStimulus(1'b0, 4'h0, '0, 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d_count", v), got.size(), vecs[v].exp_cnt);
      for (int j = 0; j < vecs[v].exp_cnt; j++)
        if (j < got.size())
          checkOutput($sformatf("vec%0d_val%0d", v, j), got[j], vecs[v].exp_vals[j]);
      checkOutput($sformatf("vec%0d_overflow", v), overflow, 0);
    end

    // Asynchronous reset mid-FILL with five entries buffered.
    doReset();
    applyStimulus(1'b1, 4'h0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'hF, dw, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0001, dw, 1'b1, 1'b0);
    #2;
    checkOutput("rst_pre_tvalid", bus.coeff_tvalid, 1);
    checkOutput("rst_pre_req_more", bus.req_more, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_tvalid", bus.coeff_tvalid, 0);
    checkOutput("rst_req_more", bus.req_more, 0);
    checkOutput("rst_idx", bus.coeff_idx, 0);
    checkOutput("rst_tdata", bus.coeff_tdata, 0);
    checkOutput("rst_tlast", bus.coeff_tlast, 0);
    start         = 1'b0;
    bus.in_tvalid = 1'b0;
    modelReset();
    rst = 1'b0;
    applyStimulus(1'b0, 4'h0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'h0, '0, 1'b0, 1'b1);
    #1;
    checkOutput("rst_level_zero", bus.coeff_tvalid, 0);

    // Full mask, sink always ready, sampler paced by req_more.
    doReset();
    applyStimulus(1'b1, 4'h0, '0, 1'b0, 1'b0);
    got.delete();
    last_pos = -1;
    runToDone(0, 2000);
    checkOutput("full_count", got.size(), 256);
    bad = 0;
    foreach (got[k]) if (got[k] != 12'(k)) bad++;
    checkOutput("full_order_errors", bad, 0);
    checkOutput("full_tlast_pos", last_pos, 255);
    checkOutput("full_overflow", overflow, 0);

    // Truncation: wr_total reaches 254, next full word writes only lanes 0 and 1.
    doReset();
    applyStimulus(1'b1, 4'h0, '0, 1'b0, 1'b0);
    got.delete();
    runToDone(1, 2000);
    checkOutput("trunc_count", got.size(), 256);
    if (got.size() == 256) begin
      checkOutput("trunc_252", got[252], 252);
      checkOutput("trunc_253", got[253], 253);
      checkOutput("trunc_254", got[254], 256);
      checkOutput("trunc_255", got[255], 257);
    end
    checkOutput("trunc_overflow", overflow, 0);

    // Backpressure: five full words with the sink stalled.
    doReset();
    applyStimulus(1'b1, 4'h0, '0, 1'b0, 1'b0);
    for (int w = 0; w < 5; w++)
      applyStimulus(1'b0, 4'hF, {$urandom, $urandom}, 1'b1, 1'b0);
    #1;
    checkOutput("bp_overflow", overflow, 1);
    checkOutput("bp_req_more", bus.req_more, 0);
    checkOutput("bp_tvalid", bus.coeff_tvalid, 1);
    got.delete();
    repeat (20) applyStimulus(1'b0, 4'h0, '0, 1'b0, 1'b1);
    checkOutput("bp_stored", got.size(), 16);

`ifdef REJECT_STATS_EN
    doReset();
    applyStimulus(1'b1, 4'h0, '0, 1'b0, 1'b0);
    for (int w = 0; w < 10; w++)
      applyStimulus(1'b0, 4'b0001, dw, 1'b1, 1'b0);
    #1;
    checkOutput("stats_30", rej_count, 30);
    runToDone(0, 2000);
    applyStimulus(1'b1, 4'h0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("stats_cleared", rej_count, 0);
`endif

    // Randomized polynomials with random masks, valid and ready.
    doReset();
    applyStimulus(1'b1, 4'h0, '0, 1'b0, 1'b0);
    runToDone(2, 5000);
    doReset();
    applyStimulus(1'b1, 4'h0, '0, 1'b0, 1'b0);
    runToDone(6, 5000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
